// File: rtl/lx32_arch_pkg.sv
// Core architecture constants and basic datapath types for the lx32 core.
package lx32_arch_pkg;

    localparam int XLEN     = 32;
    localparam int PC_WIDTH = 32;

    typedef logic [XLEN-1:0]     data_t;
    typedef logic [PC_WIDTH-1:0] addr_t;

endpackage

// File: rtl/lx32_mem_pkg.sv
// Types shared by the lx32 memory-port arbiter: byte strobes, FSM states,
// transaction owner and the request bundle driven onto the memory port.
package lx32_mem_pkg;

    import lx32_arch_pkg::*;

    localparam int STRB_WIDTH = XLEN / 8;

    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_LSU
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_e;

    typedef struct packed {
        logic  we;
        strb_t be;
        addr_t addr;
        data_t wdata;
    } mem_req_t;

endpackage

// File: rtl/lx32_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU, one
// outstanding transaction. Define LX32_ARB_RR_EN for round-robin selection
// instead of LSU priority with the IF anti-starvation counter.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | arbitrate, drive mem_* from the selected requester
// WAIT_IF  | IF transaction granted, waiting for mem_rvalid_i
// WAIT_LSU | LSU transaction granted, waiting for mem_rvalid_i
module lx32_mem_arbiter
    import lx32_arch_pkg::*;
    import lx32_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic  clk,
    input  logic  rst_n,

    input  logic  if_req_i,
    input  addr_t if_addr_i,
    output logic  if_gnt_o,
    output logic  if_rvalid_o,
    output data_t if_rdata_o,

    input  logic  lsu_req_i,
    input  logic  lsu_we_i,
    input  strb_t lsu_be_i,
    input  addr_t lsu_addr_i,
    input  data_t lsu_wdata_i,
    output logic  lsu_gnt_o,
    output logic  lsu_rvalid_o,
    output data_t lsu_rdata_o,

    output logic  mem_req_o,
    output logic  mem_we_o,
    output strb_t mem_be_o,
    output addr_t mem_addr_o,
    output data_t mem_wdata_o,
    input  logic  mem_gnt_i,
    input  logic  mem_rvalid_i,
    input  data_t mem_rdata_i,

    output logic  busy_o
);

    arb_state_e state_q, state_d;
    logic       lock_vld_q;
    owner_e     lock_own_q;
    owner_e     both_pick;
    owner_e     sel_own;
    logic       any_req;
    mem_req_t   sel_req;

    assign any_req = if_req_i | lsu_req_i;

`ifdef LX32_ARB_RR_EN
    owner_e last_own_q;

    assign both_pick = (last_own_q == OWN_LSU) ? OWN_IF : OWN_LSU;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_own_q <= OWN_LSU;
        end else if (if_gnt_o) begin
            last_own_q <= OWN_IF;
        end else if (lsu_gnt_o) begin
            last_own_q <= OWN_LSU;
        end
    end
`else
    logic [CNT_W-1:0] starve_cnt_q;

    assign both_pick = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? OWN_IF : OWN_LSU;

    // Counts LSU wins while IF is kept waiting; any IF grant or IF going quiet resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (if_gnt_o) begin
                starve_cnt_q <= '0;
            end else if (lsu_gnt_o && if_req_i) begin
                if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                end
            end else if (!if_req_i) begin
                starve_cnt_q <= '0;
            end
        end
    end
`endif

    // A stalled request keeps its owner until granted, so mem_* stay stable.
    always_comb begin
        sel_own = OWN_IF;
        if (lock_vld_q) begin
            sel_own = lock_own_q;
        end else if (if_req_i && lsu_req_i) begin
            sel_own = both_pick;
        end else if (lsu_req_i) begin
            sel_own = OWN_LSU;
        end
    end

    always_comb begin
        if (sel_own == OWN_IF) begin
            sel_req = '{we: 1'b0, be: '1, addr: if_addr_i, wdata: '0};
        end else begin
            sel_req = '{we: lsu_we_i, be: lsu_be_i, addr: lsu_addr_i, wdata: lsu_wdata_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= OWN_IF;
        end else if (state_q == IDLE && any_req) begin
            if (mem_gnt_i) begin
                lock_vld_q <= 1'b0;
            end else begin
                lock_vld_q <= 1'b1;
                lock_own_q <= sel_own;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req && mem_gnt_i) begin
                    state_d = (sel_own == OWN_IF) ? WAIT_IF : WAIT_LSU;
                end
            end
            WAIT_IF, WAIT_LSU: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o    = 1'b0;
        busy_o       = 1'b0;
        if_gnt_o     = 1'b0;
        lsu_gnt_o    = 1'b0;
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_req_o = any_req;
                if_gnt_o  = any_req && mem_gnt_i && (sel_own == OWN_IF);
                lsu_gnt_o = any_req && mem_gnt_i && (sel_own == OWN_LSU);
            end
            WAIT_IF: begin
                busy_o      = 1'b1;
                if_rvalid_o = mem_rvalid_i;
            end
            WAIT_LSU: begin
                busy_o       = 1'b1;
                lsu_rvalid_o = mem_rvalid_i;
            end
            default: ;
        endcase
    end

    assign mem_we_o    = mem_req_o & sel_req.we;
    assign mem_be_o    = mem_req_o ? sel_req.be : '0;
    assign mem_addr_o  = sel_req.addr;
    assign mem_wdata_o = sel_req.wdata;

    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;

endmodule
